ex_muldiv_ctrl: RTL and testbench

Sequencing controller for the EX-stage multi-cycle arithmetic units: the 2-stage pipelined multiplier and the iterative divider. It decodes the mul/div bits of the one-hot ALU op vector and launches the matching unit. It stalls the EX stage until the result is captured, then holds that result until the MEM stage accepts it. Pipeline flushes cancel in-flight work.

---
 rtl/ex_muldiv_ctrl.sv | 128 ++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage sequencer for the pipelined multiplier and the
// iterative divider. It decodes mul/div ops, launches the matching unit,
// stalls EX until the result is captured, and holds the result until MEM
// accepts it. A flush cancels any in-flight operation.
module ex_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [18:0] ex_op,
  input  logic        ex_flush,
  input  logic        ms_allowin,
  output logic        es_ready_go,
  output logic [31:0] md_result,
  output logic        mul_signed,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_cancel,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic [63:0] mul_p
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;

  logic        is_md, is_mul, is_div;
  logic [31:0] mul_sel, div_sel;
  logic        unused_op_bits;

  assign is_mul  = |ex_op[18:16];
  assign is_div  = |ex_op[15:12];
  assign is_md   = ex_valid & (is_mul | is_div);
  assign mul_sel = ex_op[16] ? mul_p[31:0] : mul_p[63:32];
  assign div_sel = (ex_op[12] | ex_op[14]) ? div_q : div_r;

  // Non-mul/div op bits are decoded elsewhere in EX.
  assign unused_op_bits = ^ex_op[11:0];

  // State, latency counter and result buffer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Next-state, counter and capture logic; a flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (ex_flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (is_md) begin
            if (is_mul) begin
              // The accept cycle already counts toward the latency, so a
              // single-cycle multiplier captures immediately.
              if (MUL_LAT == 1) begin
                res_d   = mul_sel;
                state_d = S_DONE;
              end else begin
                cnt_d   = CNT_LOAD;
                state_d = S_MUL_WAIT;
              end
            end else begin
              state_d = S_DIV_WAIT;
            end
          end
        end
        S_MUL_WAIT: begin
          // cnt was loaded with MUL_LAT-1 in the accept cycle, so reaching 1
          // here marks the cycle in which mul_p becomes valid.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            res_d   = mul_sel;
            cnt_d   = '0;
            state_d = S_DONE;
          end
        end
        S_DIV_WAIT: begin
          if (div_done) begin
            res_d   = div_sel;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (ms_allowin) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake, launch/abort pulses and operand-sign decode.
  always_comb begin
    es_ready_go = ~is_md | ((state_q == S_DONE) & ~ex_flush);
    div_start   = (state_q == S_IDLE) & is_md & is_div & ~ex_flush;
    div_cancel  = (state_q == S_DIV_WAIT) & ex_flush;
    md_result   = res_q;
    mul_signed  = ex_op[16] | ex_op[17];
    div_signed  = ex_op[12] | ex_op[13];
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed testbench for ex_muldiv_ctrl (MUL_LAT=2 main instance, MUL_LAT=3
// second instance sharing the same stimulus).
module tb_ex_muldiv_ctrl;

  localparam logic [18:0] OP_ADD   = 19'd1 << 0;
  localparam logic [18:0] OP_DIV   = 19'd1 << 12;
  localparam logic [18:0] OP_MOD   = 19'd1 << 13;
  localparam logic [18:0] OP_DIVU  = 19'd1 << 14;
  localparam logic [18:0] OP_MUL   = 19'd1 << 16;
  localparam logic [18:0] OP_MULH  = 19'd1 << 17;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [18:0] ex_op;
  logic        ex_flush;
  logic        ms_allowin;
  logic        div_done;
  logic [31:0] div_q, div_r;
  logic [63:0] mul_p;

  logic        es_ready_go, mul_signed, div_start, div_signed, div_cancel;
  logic [31:0] md_result;
  logic        es_ready_go3, mul_signed3, div_start3, div_signed3, div_cancel3;
  logic [31:0] md_result3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_flush(ex_flush), .ms_allowin(ms_allowin), .es_ready_go(es_ready_go),
    .md_result(md_result), .mul_signed(mul_signed), .div_start(div_start),
    .div_signed(div_signed), .div_cancel(div_cancel), .div_done(div_done),
    .div_q(div_q), .div_r(div_r), .mul_p(mul_p)
  );

  ex_muldiv_ctrl #(.MUL_LAT(3)) dut3 (
    .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_flush(ex_flush), .ms_allowin(ms_allowin), .es_ready_go(es_ready_go3),
    .md_result(md_result3), .mul_signed(mul_signed3), .div_start(div_start3),
    .div_signed(div_signed3), .div_cancel(div_cancel3), .div_done(div_done),
    .div_q(div_q), .div_r(div_r), .mul_p(mul_p)
  );

  // Advance to 1 time unit after the next rising edge (start of next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    ex_valid   = 1'b0;
    ex_op      = '0;
    ex_flush   = 1'b0;
    ms_allowin = 1'b1;
    div_done   = 1'b0;
    div_q      = '0;
    div_r      = '0;
    mul_p      = '0;
    @(posedge clk);
    #2 resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL reset_rg: got %b exp 1", es_ready_go); end
    n_tests++; if (md_result !== 32'h0) begin n_fail++; $display("FAIL reset_md: got %h exp 00000000", md_result); end
    n_tests++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL reset_div_start: got %b exp 0", div_start); end
    n_tests++; if (div_cancel !== 1'b0) begin n_fail++; $display("FAIL reset_div_cancel: got %b exp 0", div_cancel); end
  endtask

  task automatic test_mul();
    do_reset();
    // mulh: accept at T=0
    ex_valid = 1'b1; ex_op = OP_MULH; #1;
    n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL mulh_rg_t0: got %b exp 0", es_ready_go); end
    n_tests++; if (mul_signed !== 1'b1) begin n_fail++; $display("FAIL mulh_signed: got %b exp 1", mul_signed); end
    n_tests++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL mulh_no_div_start: got %b exp 0", div_start); end
    step(); // T=1
    mul_p = 64'h0000_0001_FFFF_FFFE; #1;
    n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL mulh_rg_t1: got %b exp 0", es_ready_go); end
    step(); // T=2
    mul_p = '0; #1;
    n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL mulh_rg_t2: got %b exp 1", es_ready_go); end
    n_tests++; if (md_result !== 32'h0000_0001) begin n_fail++; $display("FAIL mulh_md_t2: got %h exp 00000001", md_result); end
    step(); // T=3 back to IDLE
    ex_valid = 1'b0; ex_op = '0;
    do_reset();
    // mul: low word selected
    ex_valid = 1'b1; ex_op = OP_MUL;
    step();
    mul_p = 64'h0000_0001_FFFF_FFFE;
    step();
    mul_p = '0; #1;
    n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL mul_rg_t2: got %b exp 1", es_ready_go); end
    n_tests++; if (md_result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_md_t2: got %h exp fffffffe", md_result); end
    ex_valid = 1'b0; ex_op = '0;
  endtask

  task automatic test_div();
    do_reset();
    // mod accepted at T=0; a div_done in the accept cycle must be ignored
    ex_valid = 1'b1; ex_op = OP_MOD; div_done = 1'b1; div_q = 32'h9; div_r = 32'h9; #1;
    n_tests++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL mod_div_start_t0: got %b exp 1", div_start); end
    n_tests++; if (div_signed !== 1'b1) begin n_fail++; $display("FAIL mod_div_signed: got %b exp 1", div_signed); end
    for (int t = 1; t <= 5; t++) begin
      step();
      div_done = 1'b0;
      if (t == 5) begin div_done = 1'b1; div_q = 32'h7; div_r = 32'h3; end
      #1;
      n_tests++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL mod_div_start_t%0d: got %b exp 0", t, div_start); end
      n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL mod_rg_t%0d: got %b exp 0", t, es_ready_go); end
    end
    step(); // T=6
    div_done = 1'b0; div_q = '0; div_r = '0; #1;
    n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL mod_rg_t6: got %b exp 1", es_ready_go); end
    n_tests++; if (md_result !== 32'h3) begin n_fail++; $display("FAIL mod_md_t6: got %h exp 00000003", md_result); end
    step();
    ex_valid = 1'b0; ex_op = '0;
  endtask

  task automatic test_stall();
    do_reset();
    ms_allowin = 1'b0;
    ex_valid = 1'b1; ex_op = OP_DIVU; #1;
    n_tests++; if (div_signed !== 1'b0) begin n_fail++; $display("FAIL divu_signed: got %b exp 0", div_signed); end
    step(); // T=1
    div_done = 1'b1; div_q = 32'h55; div_r = 32'h11;
    step(); // T=2..4 DONE with MEM blocked
    div_done = 1'b0; div_q = '0; div_r = '0;
    for (int t = 2; t <= 5; t++) begin
      if (t == 5) ms_allowin = 1'b1;
      #1;
      n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL stall_rg_t%0d: got %b exp 1", t, es_ready_go); end
      n_tests++; if (md_result !== 32'h55) begin n_fail++; $display("FAIL stall_md_t%0d: got %h exp 00000055", t, md_result); end
      n_tests++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL stall_div_start_t%0d: got %b exp 0", t, div_start); end
      step();
    end
    // T=6: IDLE, next divu accepted
    #1;
    n_tests++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL stall_next_div_start: got %b exp 1", div_start); end
    n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL stall_next_rg: got %b exp 0", es_ready_go); end
    ex_valid = 1'b0; ex_op = '0;
  endtask

  task automatic test_flush();
    do_reset();
    ex_valid = 1'b1; ex_op = OP_DIV;
    step(); step(); // T=2
    ex_flush = 1'b1; #1;
    n_tests++; if (div_cancel !== 1'b1) begin n_fail++; $display("FAIL flush_cancel_t2: got %b exp 1", div_cancel); end
    n_tests++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL flush_start_t2: got %b exp 0", div_start); end
    n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL flush_rg_t2: got %b exp 0", es_ready_go); end
    step(); // T=3 late div_done
    ex_flush = 1'b0; ex_valid = 1'b0; div_done = 1'b1; div_q = 32'hDEAD; div_r = 32'hBEEF; #1;
    n_tests++; if (div_cancel !== 1'b0) begin n_fail++; $display("FAIL flush_cancel_t3: got %b exp 0", div_cancel); end
    step(); // T=4: must be IDLE, new div accepted
    div_done = 1'b0; ex_valid = 1'b1; ex_op = OP_DIV; #1;
    n_tests++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL flush_idle_start_t4: got %b exp 1", div_start); end
    n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL flush_idle_rg_t4: got %b exp 0", es_ready_go); end
    n_tests++; if (md_result !== 32'h0) begin n_fail++; $display("FAIL flush_md_t4: got %h exp 00000000", md_result); end
    // flush and div_done together
    do_reset();
    ex_valid = 1'b1; ex_op = OP_DIV;
    step(); step(); // T=2
    ex_flush = 1'b1; div_done = 1'b1; div_q = 32'h77; div_r = 32'h66; #1;
    n_tests++; if (div_cancel !== 1'b1) begin n_fail++; $display("FAIL flushdone_cancel: got %b exp 1", div_cancel); end
    step(); // T=3
    ex_flush = 1'b0; div_done = 1'b0; #1;
    n_tests++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL flushdone_idle_start: got %b exp 1", div_start); end
    n_tests++; if (md_result !== 32'h0) begin n_fail++; $display("FAIL flushdone_md: got %h exp 00000000", md_result); end
    ex_valid = 1'b0; ex_op = '0;
  endtask

  task automatic test_add();
    do_reset();
    ex_valid = 1'b1; ex_op = OP_ADD; #1;
    n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL add_rg: got %b exp 1", es_ready_go); end
    n_tests++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL add_div_start: got %b exp 0", div_start); end
    step();
    ex_op = OP_MUL; #1;
    n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL add_then_mul_rg: got %b exp 0", es_ready_go); end
    ex_valid = 1'b0; ex_op = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_valid = 1'b1; ex_op = OP_MUL; mul_p = 64'h0000_0000_0000_1111;
    step(); step(); #1; // T=2 DONE
    n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL b2b_rg_t2: got %b exp 1", es_ready_go); end
    mul_p = 64'h0000_0000_0000_2222;
    step(); #1; // T=3 IDLE accept of the second mul
    n_tests++; if (es_ready_go !== 1'b0) begin n_fail++; $display("FAIL b2b_rg_t3: got %b exp 0", es_ready_go); end
    step(); step(); #1; // T=5 DONE
    n_tests++; if (es_ready_go !== 1'b1) begin n_fail++; $display("FAIL b2b_rg_t5: got %b exp 1", es_ready_go); end
    n_tests++; if (md_result !== 32'h2222) begin n_fail++; $display("FAIL b2b_md_t5: got %h exp 00002222", md_result); end
    ex_valid = 1'b0; ex_op = '0; mul_p = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_valid = 1'b1; ex_op = OP_MUL; mul_p = 64'h1234_5678_9ABC_DEF0;
    step(); step(); // T=2 DONE, result captured
    step(); // T=3 IDLE, second mul accepted
    step(); // T=4 MUL_WAIT
    #1;
    n_tests++; if (md_result !== 32'h9ABC_DEF0) begin n_fail++; $display("FAIL areset_pre_md: got %h exp 9abcdef0", md_result); end
    resetn = 1'b0; #1;
    n_tests++; if (md_result !== 32'h0) begin n_fail++; $display("FAIL areset_md: got %h exp 00000000", md_result); end
    ex_op = OP_DIV; #1;
    n_tests++; if (div_start !== 1'b1) begin n_fail++; $display("FAIL areset_idle: got %b exp 1", div_start); end
    n_tests++; if (div_cancel !== 1'b0) begin n_fail++; $display("FAIL areset_no_cancel: got %b exp 0", div_cancel); end
    resetn = 1'b1;
    ex_valid = 1'b0; ex_op = '0; mul_p = '0;
    step();
  endtask

  task automatic test_lat3();
    do_reset();
    ex_valid = 1'b1; ex_op = OP_MUL; #1;
    n_tests++; if (es_ready_go3 !== 1'b0) begin n_fail++; $display("FAIL lat3_rg_t0: got %b exp 0", es_ready_go3); end
    step(); #1;
    n_tests++; if (es_ready_go3 !== 1'b0) begin n_fail++; $display("FAIL lat3_rg_t1: got %b exp 0", es_ready_go3); end
    step();
    mul_p = 64'h0000_00AB_0000_00CD; #1;
    n_tests++; if (es_ready_go3 !== 1'b0) begin n_fail++; $display("FAIL lat3_rg_t2: got %b exp 0", es_ready_go3); end
    step();
    mul_p = '0; #1;
    n_tests++; if (es_ready_go3 !== 1'b1) begin n_fail++; $display("FAIL lat3_rg_t3: got %b exp 1", es_ready_go3); end
    n_tests++; if (md_result3 !== 32'hCD) begin n_fail++; $display("FAIL lat3_md_t3: got %h exp 000000cd", md_result3); end
    ex_valid = 1'b0; ex_op = '0;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_stall();
    test_flush();
    test_add();
    test_back_to_back();
    test_async_reset();
    test_lat3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end

endmodule
